// File: rtl/fb_scanout.sv
`default_nettype none
// ============================================================================
//  Module   : fb_scanout
//  Purpose  : 640x480@60 VGA scan-out of a 160x120 framebuffer with 4x4 pixel
//             replication. Issues synchronous RAM reads one clock after the
//             counters and aligns color with sync through a 3-stage pipeline.
//  Revision : 1.0  initial release
// ============================================================================
module fb_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int FB_W     = 160
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [14:0] rd_addr,
    output logic        rd_en,
    input  logic [11:0] rd_data,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vblank,
    output logic        frame_start
);

    localparam logic [9:0]  C_H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0]  C_HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  C_HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  C_H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  C_V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0]  C_VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  C_VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  C_V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [14:0] C_FB_W   = 15'(FB_W);

    // stage 0: raster counters
    logic [9:0]  r_h_cnt;
    logic [9:0]  r_v_cnt;

    // stage 1: fetch request and early timing flags
    logic [14:0] r_rd_addr;
    logic        r_rd_en;
    logic        r_vblank;
    logic        r_frame_start;
    logic        r_started;
    logic        r_act1;
    logic        r_hs1;
    logic        r_vs1;

    // stage 2: waits for RAM read latency
    logic        r_act2;
    logic        r_hs2;
    logic        r_vs2;

    // stage 3: output registers
    logic [11:0] r_rgb;
    logic        r_hs3;
    logic        r_vs3;

    logic        w_active;
    logic        w_hs_n;
    logic        w_vs_n;
    logic [7:0]  w_fb_x;
    logic [6:0]  w_fb_y;
    logic [14:0] w_addr;

    // Stage-0 decode: active window, sync windows and replicated fb address
    always_comb begin
        w_active = (r_h_cnt < C_H_ACT) && (r_v_cnt < C_V_ACT);
        w_hs_n   = !((r_h_cnt >= C_HS_BEG) && (r_h_cnt < C_HS_END));
        w_vs_n   = !((r_v_cnt >= C_VS_BEG) && (r_v_cnt < C_VS_END));
        w_fb_x   = r_h_cnt[9:2];
        w_fb_y   = r_v_cnt[8:2];
        w_addr   = ({8'd0, w_fb_y} * C_FB_W) + {7'd0, w_fb_x};
    end

    // Horizontal/vertical counters; v advances on the same edge h wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt <= 10'd0;
            r_v_cnt <= 10'd0;
        end else if (r_h_cnt == C_H_LAST) begin
            r_h_cnt <= 10'd0;
            r_v_cnt <= (r_v_cnt == C_V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
        end
    end

    // Stage 1: RAM request (address held while blanking) plus frame flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_addr     <= 15'd0;
            r_rd_en       <= 1'b0;
            r_vblank      <= 1'b0;
            r_frame_start <= 1'b0;
            r_started     <= 1'b0;
            r_act1        <= 1'b0;
            r_hs1         <= 1'b1;
            r_vs1         <= 1'b1;
        end else begin
            if (w_active) begin
                r_rd_addr <= w_addr;
            end
            r_rd_en       <= w_active;
            r_vblank      <= (r_v_cnt >= C_V_ACT);
            // the (0,0) seen right after reset is not a new frame
            r_frame_start <= r_started && (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);
            r_started     <= 1'b1;
            r_act1        <= w_active;
            r_hs1         <= w_hs_n;
            r_vs1         <= w_vs_n;
        end
    end

    // Stage 2: delay flags while the RAM produces rd_data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act2 <= 1'b0;
            r_hs2  <= 1'b1;
            r_vs2  <= 1'b1;
        end else begin
            r_act2 <= r_act1;
            r_hs2  <= r_hs1;
            r_vs2  <= r_vs1;
        end
    end

    // Stage 3: register color (black outside active video) aligned with sync
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb <= 12'h000;
            r_hs3 <= 1'b1;
            r_vs3 <= 1'b1;
        end else begin
            r_rgb <= r_act2 ? rd_data : 12'h000;
            r_hs3 <= r_hs2;
            r_vs3 <= r_vs2;
        end
    end

    assign rd_addr     = r_rd_addr;
    assign rd_en       = r_rd_en;
    assign vblank      = r_vblank;
    assign frame_start = r_frame_start;
    assign vga_r       = r_rgb[11:8];
    assign vga_g       = r_rgb[7:4];
    assign vga_b       = r_rgb[3:0];
    assign vga_hs      = r_hs3;
    assign vga_vs      = r_vs3;

endmodule
`default_nettype wire

// File: tb/tb_fb_scanout.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fb_scanout
//  Purpose  : Self-checking bench for fb_scanout. Instance A keeps the full
//             horizontal timing with a short frame; instance B keeps the full
//             vertical timing with short lines. A raster model predicts every
//             output each cycle; directed literals pin key points.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fb_scanout;

    typedef struct packed {
        logic [14:0] addr;
        logic        en;
        logic        vb;
        logic        fs;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int          k;
    int          mode;
    int          n_vec;
    int          n_err;
    int          exp8[8] = '{0, 0, 0, 0, 1, 1, 1, 1};

    logic [14:0] a_addr, b_addr;
    logic        a_en, b_en;
    logic [11:0] a_rd_data, b_rd_data;
    logic [3:0]  a_r, a_g, a_b, b_r, b_g, b_b;
    logic        a_hs, a_vs, a_vb, a_fs;
    logic        b_hs, b_vs, b_vb, b_fs;

    fb_scanout #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(20),  .V_FP(2),  .V_SYNC(2),  .V_BP(2), .FB_W(160)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .rd_addr(a_addr), .rd_en(a_en),
        .rd_data(a_rd_data), .vga_r(a_r), .vga_g(a_g), .vga_b(a_b),
        .vga_hs(a_hs), .vga_vs(a_vs), .vblank(a_vb), .frame_start(a_fs)
    );

    fb_scanout #(
        .H_ACTIVE(16),  .H_FP(2),  .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33), .FB_W(160)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .rd_addr(b_addr), .rd_en(b_en),
        .rd_data(b_rd_data), .vga_r(b_r), .vga_g(b_g), .vga_b(b_b),
        .vga_hs(b_hs), .vga_vs(b_vs), .vblank(b_vb), .frame_start(b_fs)
    );

    // 25 MHz pixel clock
    initial clk = 1'b0;
    always #20 clk = ~clk;

    // edges since reset release; 0 while in reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    function automatic logic [11:0] ram_val(input int a, input int m);
        if (m != 0) return 12'hFFF;
        return 12'((a * 37 + 5) % 4096);
    endfunction

    function automatic logic [14:0] fb_addr(input int h, input int v);
        return 15'((v / 4) * 160 + h / 4);
    endfunction

    // Synchronous-read RAMs; garbage when not enabled so blanking must mask it
    always @(posedge clk) begin
        a_rd_data <= a_en ? ram_val(int'(a_addr), mode) : 12'hBAD;
        b_rd_data <= b_en ? ram_val(int'(b_addr), mode) : 12'hBAD;
    end

    // Raster model: outputs at edge k from counter position k-1 (fetch side)
    // and k-3 (display side); the fetch address holds the last active pixel.
    function automatic exp_t model(input int kk, input int ha, input int hfp,
                                   input int hsw, input int hbp, input int va,
                                   input int vfp, input int vsw, input int vbp,
                                   input int m);
        int   htot;
        int   frame;
        int   p, h, v, q;
        exp_t e;
        htot  = ha + hfp + hsw + hbp;
        frame = htot * (va + vfp + vsw + vbp);
        e     = '0;
        e.hs  = 1'b1;
        e.vs  = 1'b1;
        if (kk == 0) return e;
        p    = (kk - 1) % frame;
        h    = p % htot;
        v    = p / htot;
        e.en = (h < ha) && (v < va);
        e.vb = (v >= va);
        e.fs = (p == 0) && (kk > 1);
        if (v >= va)     e.addr = fb_addr(ha - 1, va - 1);
        else if (h >= ha) e.addr = fb_addr(ha - 1, v);
        else             e.addr = fb_addr(h, v);
        if (kk >= 3) begin
            q    = (kk - 3) % frame;
            h    = q % htot;
            v    = q / htot;
            e.rgb = ((h < ha) && (v < va)) ? ram_val(int'(fb_addr(h, v)), m) : 12'h000;
            e.hs  = !((h >= ha + hfp) && (h < ha + hfp + hsw));
            e.vs  = !((v >= va + vfp) && (v < va + vfp + vsw));
        end
        return e;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (k=%0d)", nm, act, req, k);
        end
    endtask

    task automatic wait_k(input int t);
        int g;
        g = 0;
        while (k != t && g < 100000) begin
            @(negedge clk);
            g++;
        end
        if (k != t) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_k: got %0d, required %0d", k, t);
        end
    endtask

    task automatic chk_reset(input string tag);
        check({tag, " a_addr"}, 64'(a_addr), 64'd0);
        check({tag, " a_en"},   64'(a_en),   64'd0);
        check({tag, " a_rgb"},  64'({a_r, a_g, a_b}), 64'd0);
        check({tag, " a_hs"},   64'(a_hs),   64'd1);
        check({tag, " a_vs"},   64'(a_vs),   64'd1);
        check({tag, " a_vb"},   64'(a_vb),   64'd0);
        check({tag, " a_fs"},   64'(a_fs),   64'd0);
        check({tag, " b_vs"},   64'(b_vs),   64'd1);
        check({tag, " b_addr"}, 64'(b_addr), 64'd0);
    endtask

    // Per-cycle comparison of both instances against the model
    exp_t ea, eb, aa, ab;
    always @(negedge clk) begin
        ea = model(k, 640, 16, 96, 48, 20, 2, 2, 2, mode);
        eb = model(k, 16, 2, 4, 2, 480, 10, 2, 33, mode);
        aa = {a_addr, a_en, a_vb, a_fs, a_r, a_g, a_b, a_hs, a_vs};
        ab = {b_addr, b_en, b_vb, b_fs, b_r, b_g, b_b, b_hs, b_vs};
        check("model_a", 64'(aa), 64'(ea));
        check("model_b", 64'(ab), 64'(eb));
    end

    // Pulse-width and phase monitors with hand-computed literals
    int  a_hs_run, b_vs_run, b_vb_run, a_fs_last, b_fs_last;
    logic a_hs_prev, b_vs_prev, b_vb_prev, a_fs_prev, b_fs_prev;
    always @(negedge clk) begin
        if (!rst_n) begin
            a_hs_run = 0; b_vs_run = 0; b_vb_run = 0; a_fs_last = 0; b_fs_last = 0;
            a_hs_prev = 1'b1; b_vs_prev = 1'b1; b_vb_prev = 1'b0;
            a_fs_prev = 1'b0; b_fs_prev = 1'b0;
        end else begin
            if (!a_hs) a_hs_run++;
            if (a_hs_prev && !a_hs) check("a_hs_fall_phase", 64'(k % 800), 64'd659);
            if (!a_hs_prev && a_hs) begin
                check("a_hs_low_width", 64'(a_hs_run), 64'd96);
                a_hs_run = 0;
            end
            if (!b_vs) b_vs_run++;
            if (b_vs_prev && !b_vs) check("b_vs_fall_phase", 64'(k % 12600), 64'd11763);
            if (!b_vs_prev && b_vs) begin
                check("b_vs_low_width", 64'(b_vs_run), 64'd48);
                b_vs_run = 0;
            end
            if (b_vb) b_vb_run++;
            if (!b_vb_prev && b_vb) check("b_vblank_rise", 64'(k % 12600), 64'd11521);
            if (b_vb_prev && !b_vb) begin
                check("b_vblank_width", 64'(b_vb_run), 64'd1080);
                b_vb_run = 0;
            end
            if (a_fs_prev) check("a_fs_width", 64'(a_fs), 64'd0);
            if (a_fs) begin
                check("a_fs_phase", 64'(k % 20800), 64'd1);
                check("a_fs_not_first", 64'(k > 20800), 64'd1);
                if (a_fs_last != 0) check("a_fs_spacing", 64'(k - a_fs_last), 64'd20800);
                a_fs_last = k;
            end
            if (b_fs_prev) check("b_fs_width", 64'(b_fs), 64'd0);
            if (b_fs) begin
                check("b_fs_phase", 64'(k % 12600), 64'd1);
                check("b_fs_not_first", 64'(k > 12600), 64'd1);
                if (b_fs_last != 0) check("b_fs_spacing", 64'(k - b_fs_last), 64'd12600);
                b_fs_last = k;
            end
            a_hs_prev = a_hs; b_vs_prev = b_vs; b_vb_prev = b_vb;
            a_fs_prev = a_fs; b_fs_prev = b_fs;
        end
    end

    // Directed sequence
    initial begin
        n_vec = 0;
        n_err = 0;
        mode  = 0;
        rst_n = 1'b1;
        #5 rst_n = 1'b0;
        repeat (4) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;

        for (int i = 1; i <= 8; i++) begin
            wait_k(i);
            check("a_addr_first8", 64'(a_addr), 64'(exp8[i-1]));
            if (i == 3) check("a_rgb_pix0", 64'({a_r, a_g, a_b}), 64'h005);
            if (i == 7) check("a_rgb_pix4", 64'({a_r, a_g, a_b}), 64'h02A);
        end
        wait_k(640);   check("a_addr_h639_l0", 64'(a_addr), 64'd159);
                       check("a_en_h639",      64'(a_en),   64'd1);
        wait_k(641);   check("a_en_h640",      64'(a_en),   64'd0);
                       check("a_addr_hold",    64'(a_addr), 64'd159);
        wait_k(3040);  check("a_addr_h639_l3", 64'(a_addr), 64'd159);
        wait_k(3201);  check("a_addr_l4_start", 64'(a_addr), 64'd160);
        wait_k(11425); check("b_addr_l476",    64'(b_addr), 64'd19040);
        wait_k(11512); check("b_addr_last",    64'(b_addr), 64'd19043);
                       check("b_en_last",      64'(b_en),   64'd1);
        wait_k(11520); check("b_vb_l479",      64'(b_vb),   64'd0);
        wait_k(11521); check("b_vb_l480",      64'(b_vb),   64'd1);
                       check("b_en_l480",      64'(b_en),   64'd0);
                       check("b_addr_hold",    64'(b_addr), 64'd19043);

        // asynchronous reset mid-frame, between clock edges
        wait_k(50000);
        @(posedge clk);
        #7 rst_n = 1'b0;
        #1 chk_reset("async_reset");
        repeat (3) @(negedge clk);
        mode  = 1;
        rst_n = 1'b1;

        wait_k(3);     check("a_rgb_fff_first", 64'({a_r, a_g, a_b}), 64'hFFF);
        wait_k(643);   check("a_rgb_blank",     64'({a_r, a_g, a_b}), 64'h000);
        wait_k(658);   check("a_hs_before",     64'(a_hs), 64'd1);
        wait_k(659);   check("a_hs_after",      64'(a_hs), 64'd0);
        wait_k(20900);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
